// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the s2 decode issue controller.
//   imm_type_e  - immediate selector codes; 110/111 are illegal
//   issue_pkt_t - fields held in the decode->execute stage register
//   is_illegal_imm() - flags the two reserved immediate codes
package decode_pkg;

  localparam int NREGS     = 32;
  localparam int REG_W     = $clog2(NREGS);
  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_J    = 3'b100,
    IMM_U    = 3'b101,
    IMM_ILL6 = 3'b110,
    IMM_ILL7 = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             wr_rd;
    logic [2:0]       imm_type;
    logic             illegal;
  } issue_pkt_t;

  function automatic logic is_illegal_imm(input logic [2:0] t);
    return t[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: pending-write bit per architectural register.
//   set_en/set_idx    - mark a destination pending (issue)
//   clr_en/clr_idx    - writeback retire; also bypassed into the lookups
//   kill_en/kill_idx  - drop the pending bit of a flushed instruction
//   rs1/rs2/rd + use flags -> haz_rs1/haz_rs2/haz_rd
// Bit 0 (x0) never becomes pending.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic             kill_en,
  input  logic [REG_W-1:0] kill_idx,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             wr_rd,
  output logic             haz_rs1,
  output logic             haz_rs2,
  output logic             haz_rd
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] eff_pend;

  // Same-cycle writeback bypass: a retiring register is already free.
  always_comb begin
    eff_pend = pend_q;
    if (clr_en) eff_pend[clr_idx] = 1'b0;
  end

  assign haz_rs1 = use_rs1 & eff_pend[rs1];
  assign haz_rs2 = use_rs2 & eff_pend[rs2];
  assign haz_rd  = wr_rd   & eff_pend[rd];

  // Clears first, set last so a new issue outranks a retire of the same reg.
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < NREGS; i++) begin
      if (kill_en && kill_idx == REG_W'(i)) pend_d[i] = 1'b0;
      if (clr_en  && clr_idx  == REG_W'(i)) pend_d[i] = 1'b0;
      if (set_en  && set_idx  == REG_W'(i)) pend_d[i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: hazard-checked issue from decode into a single
// registered valid/ready stage toward execute.
//   d_*     - decoded instruction from fetch (d_ready is combinational)
//   x_*     - staged instruction toward execute
//   wb_*    - writeback retire, frees a pending register
//   flush   - kills the staged instruction, blocks issue this cycle
//   stall_cnt - saturating count of cycles fetch was held off
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic             d_wr_rd,
  input  logic [2:0]       d_imm_type,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [REG_W-1:0] x_rs1,
  output logic [REG_W-1:0] x_rs2,
  output logic [REG_W-1:0] x_rd,
  output logic             x_wr_rd,
  output logic [2:0]       x_imm_type,
  output logic             x_illegal,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  issue_pkt_t       x_pkt_q, x_pkt_d;
  logic             x_valid_q, x_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             haz_rs1, haz_rs2, haz_rd;
  logic             hazard, accept, kill;

  // A flushed destination bit can only belong to the killed instruction,
  // because WAW hazards keep a second writer of that reg out of the stage.
  assign kill = flush & x_valid_q & x_pkt_q.wr_rd;

  decode_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept & d_wr_rd),
    .set_idx  (d_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .kill_en  (kill),
    .kill_idx (x_pkt_q.rd),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .rd       (d_rd),
    .use_rs1  (d_use_rs1),
    .use_rs2  (d_use_rs2),
    .wr_rd    (d_wr_rd),
    .haz_rs1  (haz_rs1),
    .haz_rs2  (haz_rs2),
    .haz_rd   (haz_rd)
  );

  assign hazard  = haz_rs1 | haz_rs2 | haz_rd;
  assign d_ready = ~rst & ~flush & ~hazard & (~x_valid_q | x_ready);
  assign accept  = d_valid & d_ready;

  always_comb begin
    x_pkt_d   = x_pkt_q;
    x_valid_d = x_valid_q;
    if (accept) begin
      x_pkt_d.rs1      = d_rs1;
      x_pkt_d.rs2      = d_rs2;
      x_pkt_d.rd       = d_rd;
      x_pkt_d.wr_rd    = d_wr_rd;
      x_pkt_d.imm_type = d_imm_type;
      x_pkt_d.illegal  = is_illegal_imm(d_imm_type);
      x_valid_d        = 1'b1;
    end else if (flush || x_ready) begin
      // Payload is left as-is; only valid drops.
      x_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (d_valid && !d_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pkt_q     <= '0;
      x_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      x_pkt_q     <= x_pkt_d;
      x_valid_q   <= x_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign x_valid    = x_valid_q;
  assign x_rs1      = x_pkt_q.rs1;
  assign x_rs2      = x_pkt_q.rs2;
  assign x_rd       = x_pkt_q.rd;
  assign x_wr_rd    = x_pkt_q.wr_rd;
  assign x_imm_type = x_pkt_q.imm_type;
  assign x_illegal  = x_pkt_q.illegal;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the issue rules.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_ready;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_use_rs1, d_use_rs2, d_wr_rd;
  logic [2:0]  d_imm_type;
  logic        x_valid, x_ready;
  logic [4:0]  x_rs1, x_rs2, x_rd;
  logic        x_wr_rd;
  logic [2:0]  x_imm_type;
  logic        x_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [31:0] m_pend;
  bit        m_xv, m_xwr, m_xill, m_known;
  bit [4:0]  m_rs1, m_rs2, m_rd;
  bit [2:0]  m_imm;
  int        m_stall;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_wr_rd(d_wr_rd),
    .d_imm_type(d_imm_type),
    .x_valid(x_valid), .x_ready(x_ready),
    .x_rs1(x_rs1), .x_rs2(x_rs2), .x_rd(x_rd),
    .x_wr_rd(x_wr_rd), .x_imm_type(x_imm_type), .x_illegal(x_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input int rs1, input int rs2, input int rd,
                     input bit u1, input bit u2, input bit wr, input int imm);
    d_valid = v; d_rs1 = 5'(rs1); d_rs2 = 5'(rs2); d_rd = 5'(rd);
    d_use_rs1 = u1; d_use_rs2 = u2; d_wr_rd = wr; d_imm_type = 3'(imm);
  endtask

  // One clock: check d_ready before the edge, advance the model, check state after.
  task automatic step();
    bit [31:0] eff;
    bit haz, er, acc;
    #2;
    eff = m_pend;
    if (wb_valid) eff[wb_rd] = 1'b0;
    haz = (d_use_rs1 && eff[d_rs1]) || (d_use_rs2 && eff[d_rs2]) || (d_wr_rd && eff[d_rd]);
    er  = !rst && !flush && !haz && (!m_xv || x_ready);
    chk("d_ready", {31'b0, d_ready}, {31'b0, er});
    acc = d_valid && er;
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_xv = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_xwr = 0; m_imm = 0; m_xill = 0; m_stall = 0; m_known = 1;
    end else begin
      if (flush && m_xv && m_xwr) m_pend[m_rd] = 1'b0;
      if (wb_valid) m_pend[wb_rd] = 1'b0;
      if (acc && d_wr_rd) m_pend[d_rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (d_valid && !er && m_stall != 65535) m_stall++;
      if (acc) begin
        m_xv = 1; m_rs1 = d_rs1; m_rs2 = d_rs2; m_rd = d_rd; m_xwr = d_wr_rd;
        m_imm = d_imm_type; m_xill = (d_imm_type >= 6); m_known = 1;
      end else if (flush || x_ready) begin
        m_xv = 0; m_known = 0;
      end
    end
    #1;
    chk("x_valid", {31'b0, x_valid}, {31'b0, m_xv});
    chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
    chk("pend", dut.u_sb.pend_q, m_pend);
    if (m_known) begin
      chk("x_rs1", {27'b0, x_rs1}, {27'b0, m_rs1});
      chk("x_rs2", {27'b0, x_rs2}, {27'b0, m_rs2});
      chk("x_rd", {27'b0, x_rd}, {27'b0, m_rd});
      chk("x_wr_rd", {31'b0, x_wr_rd}, {31'b0, m_xwr});
      chk("x_imm_type", {29'b0, x_imm_type}, {29'b0, m_imm});
      chk("x_illegal", {31'b0, x_illegal}, {31'b0, m_xill});
    end
  endtask

  initial begin
    rst = 1; x_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    m_pend = 0; m_xv = 0; m_known = 0; m_stall = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_xwr = 0; m_imm = 0; m_xill = 0;

    // reset
    step(); step();
    rst = 0;

    // back-to-back independent issue
    drv(1, 0, 0, 1, 0, 0, 1, 1); step();
    chk("b2b_xvalid_c1", {31'b0, x_valid}, 32'd1);
    drv(1, 0, 0, 2, 0, 0, 1, 2); step();
    drv(1, 0, 0, 3, 0, 0, 1, 5); step();
    chk("b2b_pend", dut.u_sb.pend_q, 32'h0000_000e);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 1; r <= 3; r++) begin wb_valid = 1; wb_rd = 5'(r); step(); end
    wb_valid = 0;

    // RAW stall released by same-cycle writeback
    drv(1, 0, 0, 5, 0, 0, 1, 1); step();
    drv(1, 5, 0, 6, 1, 0, 1, 2);
    repeat (3) step();
    chk("raw_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    wb_valid = 1; wb_rd = 5; step();
    chk("raw_accept_rs1", {27'b0, x_rs1}, 32'd5);
    wb_valid = 0;

    // backpressure: stage held, next instruction waits
    x_ready = 0; drv(1, 1, 2, 8, 1, 1, 0, 3);
    repeat (3) step();
    chk("bp_hold_rd", {27'b0, x_rd}, 32'd6);
    x_ready = 1; step();
    chk("bp_load_rd", {27'b0, x_rd}, 32'd8);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step();
    wb_valid = 1; wb_rd = 6; step(); wb_valid = 0;

    // flush kills the staged rd=7 and blocks issue
    x_ready = 0; drv(1, 0, 0, 7, 0, 0, 1, 4); step();
    flush = 1; drv(1, 0, 0, 9, 0, 0, 1, 1); step();
    chk("flush_xvalid", {31'b0, x_valid}, 32'd0);
    chk("flush_pend7", {31'b0, dut.u_sb.pend_q[7]}, 32'd0);
    flush = 0; x_ready = 1;

    // x0 never pending; issue beats retire on same register
    drv(1, 0, 0, 0, 0, 0, 1, 0); step();
    chk("x0_pend", dut.u_sb.pend_q, 32'h0);
    drv(1, 0, 0, 4, 0, 0, 1, 1); step();
    wb_valid = 1; wb_rd = 4; drv(1, 0, 0, 4, 0, 0, 1, 2); step();
    chk("collide_pend4", {31'b0, dut.u_sb.pend_q[4]}, 32'd1);
    wb_valid = 0;

    // illegal immediate codes
    drv(1, 0, 0, 0, 0, 0, 0, 7); step();
    chk("illegal7", {31'b0, x_illegal}, 32'd1);
    drv(1, 0, 0, 0, 0, 0, 0, 6); step();
    chk("illegal6", {31'b0, x_illegal}, 32'd1);

    // reset during a stall
    drv(1, 4, 0, 0, 1, 0, 0, 0); step(); step();
    rst = 1; step();
    chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
    chk("rst_pend", dut.u_sb.pend_q, 32'h0);
    chk("rst_xvalid", {31'b0, x_valid}, 32'd0);
    rst = 0;

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      drv($urandom_range(99) < 80, $urandom_range(7), $urandom_range(7), $urandom_range(7),
          $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(7));
      x_ready  = $urandom_range(99) < 70;
      wb_valid = $urandom_range(99) < 40;
      wb_rd    = 5'($urandom_range(7));
      flush    = $urandom_range(99) < 5;
      rst      = $urandom_range(199) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
